// File: rtl/limb_pkg.sv
// limb_pkg: shared types and widths for the Limb CPU front end
package limb_pkg;
  localparam int LIMB_ADDR_W = 8;
  localparam int LIMB_INSTR_W = 32;
  typedef enum logic [1:0] {SEQ, BRANCH, CALL, RET} res_kind_e;
  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_RESOLVE, S_HALT} fetch_state_e;
endpackage

// File: rtl/limb_call_stack.sv
// limb_call_stack: hardware return-address LIFO
module limb_call_stack #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 16,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic [DW-1:0]     depth
);
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  assign full = depth == DW'(STACK_DEPTH);
  assign empty = depth == '0;
  assign top = mem[AW'(depth - 1'b1)];
  // occupancy counter; only this needs reset since entries above depth are dead
  always_ff @(posedge clk or posedge reset)
    if (reset) depth <= '0;
    else if (push && !full) depth <= depth + 1'b1;
    else if (pop && !empty) depth <= depth - 1'b1;
  // entry storage, written at the current depth on push
  always_ff @(posedge clk)
    if (push && !full) mem[AW'(depth)] <= din;
endmodule

// File: rtl/limb_fetch.sv
// limb_fetch: program counter, instruction fetch and call/return control
module limb_fetch
  import limb_pkg::*;
#(
  parameter int ADDR_W = LIMB_ADDR_W,
  parameter int INSTR_W = LIMB_INSTR_W,
  parameter int STACK_DEPTH = 16,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               res_valid,
  input  logic [1:0]         res_kind,
  input  logic               res_taken,
  input  logic [ADDR_W-1:0]  res_target,
  output logic               halted,
  output logic               fault_ovf,
  output logic               fault_unf,
  output logic [DW-1:0]      cs_depth
);
  fetch_state_e state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pc_inc, top;
  logic push, pop, full, empty, set_ovf, set_unf;
  res_kind_e kind;
  assign kind = res_kind_e'(res_kind);
  assign pc_inc = pc + 1'b1;
  assign rom_addr = pc;
  assign halted = state == S_HALT;
  limb_call_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_inc),
    .top(top), .full(full), .empty(empty), .depth(cs_depth)
  );
  // next state, next pc and stack control; resolve inputs only matter in S_RESOLVE
  always_comb begin
    state_d = state;
    pc_d = pc;
    push = 1'b0;
    pop = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (state)
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: state_d = ir_ready ? S_RESOLVE : S_ISSUE;
      S_RESOLVE:
        if (res_valid) begin
          state_d = S_FETCH;
          case (kind)
            SEQ: pc_d = pc_inc;
            BRANCH: pc_d = res_taken ? res_target : pc_inc;
            CALL:
              if (!res_taken) pc_d = pc_inc;
              else if (full) begin
                set_ovf = 1'b1;
                state_d = S_HALT;
              end else begin
                push = 1'b1;
                pc_d = res_target;
              end
            RET:
              if (empty) begin
                set_unf = 1'b1;
                state_d = S_HALT;
              end else begin
                pop = 1'b1;
                pc_d = top;
              end
            default: ;
          endcase
        end
      default: ;
    endcase
  end
  // control state, pc and sticky fault flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_FETCH;
      pc <= '0;
      fault_ovf <= 1'b0;
      fault_unf <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      fault_ovf <= fault_ovf | set_ovf;
      fault_unf <= fault_unf | set_unf;
    end
  // instruction register: load in S_FETCH, release on the issue handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
    end else if (state == S_FETCH) begin
      ir <= rom_data;
      ir_pc <= pc;
      ir_valid <= 1'b1;
    end else if (state == S_ISSUE && ir_ready) ir_valid <= 1'b0;
endmodule

// File: tb/tb_limb_fetch.sv
// tb_limb_fetch: scoreboard bench for the fetch / call-stack unit
module tb_limb_fetch;
  import limb_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] rom_addr, ir_pc, res_target;
  logic [31:0] rom_data, ir;
  logic ir_valid, ir_ready, res_valid, res_taken, halted, fault_ovf, fault_unf;
  logic [1:0] res_kind;
  logic [4:0] cs_depth;
  logic [31:0] rom [256];
  logic [7:0] sb [$];
  logic [7:0] mstack [$];
  logic [7:0] mpc;
  int tests = 0, fails = 0;

  limb_fetch dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .res_valid(res_valid), .res_kind(res_kind), .res_taken(res_taken),
    .res_target(res_target), .halted(halted), .fault_ovf(fault_ovf),
    .fault_unf(fault_unf), .cs_depth(cs_depth)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    ir_ready = 1'b0;
    res_valid = 1'b0;
    res_kind = 2'd0;
    res_taken = 1'b0;
    res_target = 8'h00;
    step;
    reset = 1'b0;
    sb.delete();
    mstack.delete();
    sb.push_back(8'h00);
  endtask

  task automatic do_instr(input logic [1:0] kind, input logic taken, input logic [7:0] target);
    int n;
    int flt;
    logic [7:0] exp, nxt, ra;
    n = 0;
    flt = 0;
    nxt = 8'h00;
    while (!ir_valid && n < 20) begin
      step;
      n++;
    end
    tests++;
    if (ir_valid !== 1'b1) begin
      fails++;
      $display("FAIL issue_timeout: ir_valid=%b after %0d cycles, required 1", ir_valid, n);
      return;
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_empty: DUT offered ir_pc=%h with no expected fetch", ir_pc);
      return;
    end
    exp = sb.pop_front();
    if (ir_pc !== exp || ir !== rom[exp]) begin
      fails++;
      $display("FAIL fetch: ir_pc=%h ir=%h, required ir_pc=%h ir=%h", ir_pc, ir, exp, rom[exp]);
    end
    mpc = exp;
    ir_ready = 1'b1;
    step;
    ir_ready = 1'b0;
    tests++;
    if (ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_drop: ir_valid=%b, required 0", ir_valid);
    end
    case (res_kind_e'(kind))
      SEQ: nxt = mpc + 8'd1;
      BRANCH: nxt = taken ? target : mpc + 8'd1;
      CALL:
        if (!taken) nxt = mpc + 8'd1;
        else if (mstack.size() >= 16) flt = 1;
        else begin
          ra = mpc + 8'd1;
          mstack.push_back(ra);
          nxt = target;
        end
      default:
        if (mstack.size() == 0) flt = 2;
        else nxt = mstack.pop_back();
    endcase
    res_valid = 1'b1;
    res_kind = kind;
    res_taken = taken;
    res_target = target;
    step;
    res_valid = 1'b0;
    res_taken = 1'($urandom);
    res_target = 8'($urandom);
    tests++;
    if (cs_depth !== 5'(mstack.size())) begin
      fails++;
      $display("FAIL cs_depth: got %0d, required %0d", cs_depth, mstack.size());
    end
    if (flt != 0) begin
      tests++;
      if (halted !== 1'b1 || fault_ovf !== (flt == 1) || fault_unf !== (flt == 2) || rom_addr !== mpc) begin
        fails++;
        $display("FAIL fault: halted=%b ovf=%b unf=%b rom_addr=%h, required 1 %b %b %h",
                 halted, fault_ovf, fault_unf, rom_addr, flt == 1, flt == 2, mpc);
      end
      ir_ready = 1'b1;
      res_valid = 1'b1;
      repeat (3) step;
      ir_ready = 1'b0;
      res_valid = 1'b0;
      tests++;
      if (halted !== 1'b1 || ir_valid !== 1'b0 || rom_addr !== mpc) begin
        fails++;
        $display("FAIL halt_hold: halted=%b ir_valid=%b rom_addr=%h, required 1 0 %h", halted, ir_valid, rom_addr, mpc);
      end
    end else begin
      sb.push_back(nxt);
      tests++;
      if (rom_addr !== nxt) begin
        fails++;
        $display("FAIL next_pc: rom_addr=%h, required %h", rom_addr, nxt);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ir_ready = 1'b0;
    res_valid = 1'b0;
    res_kind = 2'd0;
    res_taken = 1'b0;
    res_target = 8'h00;
    #1;
    tests++;
    if ({ir_valid, halted, fault_ovf, fault_unf, cs_depth, rom_addr, ir_pc, ir} !== '0) begin
      fails++;
      $display("FAIL reset_vals: valid=%b halted=%b ovf=%b unf=%b depth=%0d pc=%h ir_pc=%h ir=%h, required all 0",
               ir_valid, halted, fault_ovf, fault_unf, cs_depth, rom_addr, ir_pc, ir);
    end
    step;
    reset = 1'b0;
    tests++;
    if (ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL release_valid: ir_valid=%b, required 0", ir_valid);
    end
  endtask

  task automatic test_throughput;
    ir_ready = 1'b1;
    res_valid = 1'b1;
    res_kind = 2'd0;
    for (int k = 0; k < 3; k++) begin
      step;
      tests++;
      if (ir_valid !== 1'b1 || ir_pc !== 8'(k) || ir !== rom[k]) begin
        fails++;
        $display("FAIL throughput_%0d: valid=%b ir_pc=%h ir=%h, required 1 %h %h", k, ir_valid, ir_pc, ir, 8'(k), rom[k]);
      end
      if (k < 2) begin
        step;
        step;
      end
    end
    ir_ready = 1'b0;
    res_valid = 1'b0;
    sb.delete();
    sb.push_back(8'h02);
  endtask

  task automatic test_stall;
    logic [31:0] ir0;
    ir0 = ir;
    for (int k = 0; k < 5; k++) begin
      res_valid = k[0];
      res_kind = 2'd1;
      res_taken = 1'b1;
      res_target = 8'h55;
      step;
      tests++;
      if (ir !== ir0 || ir_valid !== 1'b1 || rom_addr !== 8'h02) begin
        fails++;
        $display("FAIL stall_%0d: ir=%h valid=%b pc=%h, required %h 1 02", k, ir, ir_valid, rom_addr, ir0);
      end
    end
    res_valid = 1'b0;
    do_instr(2'd0, 1'b0, 8'h00);
  endtask

  task automatic test_branch;
    do_instr(2'd1, 1'b1, 8'h40);
    do_instr(2'd0, 1'b0, 8'h00);
    do_instr(2'd1, 1'b1, 8'hFF);
    do_instr(2'd1, 1'b0, 8'h33);
    do_instr(2'd1, 1'b1, 8'h10);
  endtask

  task automatic test_call_ret;
    do_instr(2'd2, 1'b1, 8'h80);
    do_instr(2'd3, 1'b0, 8'h00);
    do_instr(2'd1, 1'b1, 8'h10);
    do_instr(2'd2, 1'b1, 8'h80);
    do_instr(2'd2, 1'b1, 8'h90);
    do_instr(2'd3, 1'b1, 8'h77);
    do_instr(2'd3, 1'b0, 8'h00);
    do_instr(2'd2, 1'b0, 8'h99);
  endtask

  task automatic test_underflow;
    do_instr(2'd3, 1'b0, 8'h00);
  endtask

  task automatic test_overflow;
    do_reset;
    do_instr(2'd2, 1'b1, 8'h20);
    repeat (16) do_instr(2'd2, 1'b1, 8'h20);
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset;
    do_instr(2'd2, 1'b1, 8'h30);
    n = 0;
    while (!ir_valid && n < 20) begin
      step;
      n++;
    end
    ir_ready = 1'b1;
    step;
    ir_ready = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if ({ir_valid, halted, fault_ovf, fault_unf, cs_depth, rom_addr, ir_pc, ir} !== '0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b halted=%b depth=%0d pc=%h ir_pc=%h ir=%h, required all 0",
               ir_valid, halted, cs_depth, rom_addr, ir_pc, ir);
    end
    res_valid = 1'b1;
    res_kind = 2'd3;
    step;
    res_valid = 1'b0;
    reset = 1'b0;
    sb.delete();
    mstack.delete();
    sb.push_back(8'h00);
    do_instr(2'd0, 1'b0, 8'h00);
    do_instr(2'd3, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'hC0, 8'(i), ~8'(i), 8'h5A};
    rom[0] = 32'hA1B2C3D4;
    test_reset;
    test_throughput;
    test_stall;
    test_branch;
    test_call_ret;
    test_underflow;
    test_overflow;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
